// File: rtl/hamming_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// hamming_tx_serializer_if : nibble valid/ready handshake with error-inject
// Rev 1.0
// ============================================================================
interface hamming_tx_serializer_if;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       err_inj_en;
  logic [2:0] err_inj_pos;

  modport master (
    output data_in,
    output data_valid,
    output err_inj_en,
    output err_inj_pos,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  err_inj_en,
    input  err_inj_pos,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/hamming_tx_serializer.sv
`default_nettype none
// ============================================================================
// hamming_tx_serializer : Hamming(7,4) encoder with optional single-bit flip,
// sent LSB-first as a UART-style frame (start, 7 data bits, stop).
// Rev 1.0
// ============================================================================
module hamming_tx_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  hamming_tx_serializer_if.slave    bus,
  output logic                      o_tx_out,
  output logic                      o_tx_busy,
  output logic [6:0]                o_word_out,
  output logic                      o_word_valid,
  output logic [CNT_W-1:0]          o_frames_sent
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [7:0]       c_baud_last = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       c_last_bit  = 3'd6;
  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      r_state;
  logic [7:0]  r_baud;
  logic [2:0]  r_bit;
  logic [6:0]  r_shift;
  logic        r_tx;
  logic [6:0]  r_word;
  logic        r_word_valid;
  logic [CNT_W-1:0] r_frames;

  state_t      w_state_nxt;
  logic [7:0]  w_baud_nxt;
  logic [2:0]  w_bit_nxt;
  logic [6:0]  w_shift_nxt;
  logic        w_tx_nxt;
  logic        w_frame_done;
  logic        w_accept;
  logic        w_baud_done;
  logic [6:0]  w_cw;
  logic [6:0]  w_flip;
  logic [6:0]  w_cw_inj;

  // Codeword layout matches the downstream decoder: parity at 0,1,3.
  always_comb begin
    w_cw    = '0;
    w_cw[2] = bus.data_in[0];
    w_cw[4] = bus.data_in[1];
    w_cw[5] = bus.data_in[2];
    w_cw[6] = bus.data_in[3];
    w_cw[0] = bus.data_in[0] ^ bus.data_in[1] ^ bus.data_in[3];
    w_cw[1] = bus.data_in[0] ^ bus.data_in[2] ^ bus.data_in[3];
    w_cw[3] = bus.data_in[1] ^ bus.data_in[2] ^ bus.data_in[3];
  end

  always_comb begin
    w_flip = '0;
    if (bus.err_inj_en && (bus.err_inj_pos != 3'd7)) begin
      w_flip = 7'(7'b1 << bus.err_inj_pos);
    end
  end

  assign w_cw_inj    = w_cw ^ w_flip;
  assign w_accept    = bus.data_valid && (r_state == S_IDLE);
  assign w_baud_done = (r_baud == c_baud_last);

  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud + 8'd1;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (w_accept) begin
          w_state_nxt = S_START;
          w_shift_nxt = w_cw_inj;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit == c_last_bit) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[6:1]};
          end
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_state_nxt  = S_IDLE;
          w_baud_nxt   = '0;
          w_frame_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
      end
    endcase
  end

  // Line level is precomputed from the next state so tx_out comes straight off a flop.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_frames     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_baud       <= w_baud_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_word_valid <= w_accept;
      if (w_accept) begin
        r_word <= w_cw_inj;
      end
      if (w_frame_done) begin
        r_frames <= r_frames + c_cnt_one;
      end
    end
  end

  assign bus.data_ready = (r_state == S_IDLE);
  assign o_tx_busy      = (r_state != S_IDLE);
  assign o_tx_out       = r_tx;
  assign o_word_out     = r_word;
  assign o_word_valid   = r_word_valid;
  assign o_frames_sent  = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_hamming_tx_serializer.sv
`default_nettype none
// ============================================================================
// tb_hamming_tx_serializer : directed self-checking bench, C=4, CNT_W=8
// Rev 1.0
// ============================================================================
module tb_hamming_tx_serializer;

  localparam int C = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_out;
  logic       tx_busy;
  logic [6:0] word_out;
  logic       word_valid;
  logic [7:0] frames_sent;

  hamming_tx_serializer_if bus ();

  hamming_tx_serializer #(
    .CLKS_PER_BIT (C),
    .CNT_W        (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .o_tx_out      (tx_out),
    .o_tx_busy     (tx_busy),
    .o_word_out    (word_out),
    .o_word_valid  (word_valid),
    .o_frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_frames = 8'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ham_decode(input logic [6:0] c);
    logic [2:0] s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    if (s != 3'd0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // Present a nibble, take the accept edge, check the cycle right after it.
  task automatic start_frame(input string tag, input logic [3:0] d, input logic en,
                             input logic [2:0] pos, input logic hold, input logic [6:0] exp_cw);
    bus.data_in     = d;
    bus.err_inj_en  = en;
    bus.err_inj_pos = pos;
    bus.data_valid  = 1'b1;
    tick();
    if (!hold) bus.data_valid = 1'b0;
    check({tag, " word_out"}, word_out, exp_cw);
    check({tag, " word_valid"}, word_valid, 1'b1);
    check({tag, " start tx"}, tx_out, 1'b0);
    check({tag, " busy"}, {tx_busy, bus.data_ready}, 2'b10);
  endtask

  // Samples the 36 frame cycles starting at k+1; ends at cycle k+37.
  task automatic capture_frame(input string tag, input logic [6:0] exp_cw, input logic mid_chg,
                               output logic [6:0] rx);
    logic [35:0] obs;
    logic [35:0] exp;
    int          ready_lo;
    exp      = '1;
    exp[3:0] = 4'b0000;
    for (int s = 1; s <= 7; s++) exp[4*s +: 4] = {4{exp_cw[s-1]}};
    ready_lo = 0;
    for (int i = 0; i < 36; i++) begin
      obs[i] = tx_out;
      if (!bus.data_ready) ready_lo++;
      if (i == 1) check({tag, " word_valid drop"}, word_valid, 1'b0);
      if (mid_chg && i == 10) begin
        bus.data_in     = 4'hC;
        bus.err_inj_en  = 1'b1;
        bus.err_inj_pos = 3'd0;
      end
      tick();
    end
    for (int b = 0; b < 7; b++) rx[b] = obs[4*(b+1) + 2];
    check({tag, " tx seq"}, obs, exp);
    check({tag, " ready low cycles"}, ready_lo, 36);
    check({tag, " idle after frame"}, {tx_out, tx_busy, bus.data_ready}, 3'b101);
  endtask

  logic [6:0] rx;
  logic       bad;
  logic       tmo;
  logic [7:0] prev;
  int         cnt;
  int         nleft;

  initial begin
    rst_n           = 1'b0;
    bus.data_in     = 4'h0;
    bus.data_valid  = 1'b0;
    bus.err_inj_en  = 1'b0;
    bus.err_inj_pos = 3'd7;
    tick();
    tick();
    check("reset outputs", {tx_out, tx_busy, bus.data_ready, word_out, word_valid, frames_sent},
          {1'b1, 1'b0, 1'b1, 7'h00, 1'b0, 8'h00});
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ({tx_out, tx_busy, bus.data_ready, frames_sent} !== {1'b1, 1'b0, 1'b1, 8'h00}) bad = 1'b1;
      tick();
    end
    check("idle hold 20", bad, 1'b0);

    start_frame("f1011", 4'b1011, 1'b0, 3'd7, 1'b0, 7'h55);
    capture_frame("f1011", 7'h55, 1'b0, rx);
    exp_frames++;
    check("f1011 rx", rx, 7'h55);
    check("f1011 count", frames_sent, exp_frames);

    start_frame("f0", 4'h0, 1'b0, 3'd7, 1'b0, 7'h00);
    capture_frame("f0", 7'h00, 1'b0, rx);
    exp_frames++;
    start_frame("f1", 4'h1, 1'b0, 3'd7, 1'b0, 7'h07);
    capture_frame("f1", 7'h07, 1'b0, rx);
    exp_frames++;
    start_frame("fF", 4'hF, 1'b0, 3'd7, 1'b0, 7'h7F);
    capture_frame("fF", 7'h7F, 1'b0, rx);
    exp_frames++;

    start_frame("inj4", 4'b1011, 1'b1, 3'd4, 1'b0, 7'h45);
    capture_frame("inj4", 7'h45, 1'b0, rx);
    exp_frames++;
    check("inj4 rx", rx, 7'h45);
    check("inj4 decoded", ham_decode(rx), 4'b1011);

    start_frame("inj7", 4'b1011, 1'b1, 3'd7, 1'b0, 7'h55);
    capture_frame("inj7", 7'h55, 1'b0, rx);
    exp_frames++;
    check("inj7 count", frames_sent, exp_frames);

    // Back-to-back: valid held high, inputs changed while frame 1 is on the wire.
    bus.err_inj_en = 1'b0;
    start_frame("b2b1", 4'h3, 1'b0, 3'd7, 1'b1, 7'h1E);
    capture_frame("b2b1", 7'h1E, 1'b1, rx);
    exp_frames++;
    check("b2b1 rx", rx, 7'h1E);
    tick();
    check("b2b2 start at +37", tx_out, 1'b0);
    check("b2b2 word", {word_valid, word_out}, {1'b1, 7'h60});
    bus.data_valid = 1'b0;
    bus.err_inj_en = 1'b0;
    capture_frame("b2b2", 7'h60, 1'b0, rx);
    exp_frames++;
    check("b2b count", frames_sent, exp_frames);

    // Counter wrap: stream frames until the 8-bit count returns to zero.
    bus.data_in    = 4'h5;
    bus.data_valid = 1'b1;
    nleft = 256 - int'(exp_frames);
    prev  = exp_frames;
    tmo   = 1'b0;
    for (int f = 0; f < nleft && !tmo; f++) begin
      cnt = 0;
      while (frames_sent === prev && cnt < 60) begin
        tick();
        cnt++;
      end
      if (cnt >= 60) tmo = 1'b1;
      prev++;
    end
    bus.data_valid = 1'b0;
    exp_frames = 8'd0;
    check("wrap timeout", tmo, 1'b0);
    check("wrap count", frames_sent, exp_frames);
    tick();
    check("wrap idle", {tx_busy, bus.data_ready, tx_out}, 3'b011);

    // Asynchronous reset during data bit 3 (a 0 bit of 7'h55).
    start_frame("rstmid", 4'b1011, 1'b0, 3'd7, 1'b0, 7'h55);
    for (int i = 0; i < 18; i++) tick();
    check("rstmid pre bit3", tx_out, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstmid async", {tx_out, tx_busy, bus.data_ready, word_out, word_valid},
          {1'b1, 1'b0, 1'b1, 7'h00, 1'b0});
    check("rstmid count", frames_sent, exp_frames);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame("post", 4'h0, 1'b0, 3'd7, 1'b0, 7'h00);
    capture_frame("post", 7'h00, 1'b0, rx);
    exp_frames++;
    check("post count", frames_sent, exp_frames);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
